display_scan_ctrl: RTL

Time-multiplexed scan controller for the calculator's multi-digit 7-segment display. It latches a packed hex value from the arithmetic side through a load/ready handshake and applies it only at frame boundaries, so the display never tears. Each cycle it presents one nibble to the shared hex-to-7-segment decoder and drives the matching active-low digit enable. It adds anti-ghosting guard time and optional leading-zero blanking.

---
 rtl/display_scan_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned value updates,
// anti-ghosting guard time and optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned GUARD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic [3:0]            digit,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(DIGITS);

  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [VW-1:0]     shown_q, shown_d;
  logic [VW-1:0]     pending_q, pending_d;
  logic              pend_q, pend_d;
  logic              ready_q, ready_d;
  logic [3:0]        digit_q, digit_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_tick_q, frame_tick_d;

  logic boundary;
  logic upper_nz;
  logic suppress;

  // Counters, handshake, and decode of the next slot into registered outputs
  always_comb begin
    pcnt_d       = pcnt_q + PW'(1);
    slot_d       = slot_q;
    shown_d      = shown_q;
    pending_d    = pending_q;
    pend_d       = pend_q;
    digit_d      = 4'h0;
    an_d         = '1;
    upper_nz     = 1'b0;
    suppress     = 1'b0;

    boundary = (pcnt_q == PCNT_LAST) && (slot_q == SLOT_LAST);

    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    end

    // Commit wins in the boundary cycle; a load there is held for the next frame
    if (boundary && pend_q) begin
      shown_d = pending_q;
      pend_d  = 1'b0;
    end
    if (load && ready_q) begin
      pending_d = value;
      pend_d    = 1'b1;
    end
    ready_d = ~pend_d;

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (slot_d == SW'(i)) begin
        digit_d = shown_d[4*i +: 4];
      end
      if ((SW'(i) >= slot_d) && (shown_d[4*i +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end

    suppress = (pcnt_d < GUARD_END) ||
               (blank_lz && (slot_d != '0) && !upper_nz);

    if (!suppress) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (slot_d == SW'(i)) begin
          an_d[i] = 1'b0;
        end
      end
    end

    frame_tick_d = (pcnt_d == PCNT_LAST) && (slot_d == SLOT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      slot_q       <= '0;
      shown_q      <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      ready_q      <= 1'b1;
      digit_q      <= 4'h0;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      slot_q       <= slot_d;
      shown_q      <= shown_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      ready_q      <= ready_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign ready      = ready_q;
  assign digit      = digit_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
